// File: rtl/mem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_pkg: shared types and constants for the MEM-stage data-bus path   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_GNT  = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [31:0] c_err_data_default = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbus_req_t;

  function automatic logic [31:0] word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_dbus_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_dbus_timer: response-wait counter, flags expiry at TIMEOUT_CYC     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module mem_dbus_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = 8'd0;
    end else if (i_run) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Counter reads 0 in the first waiting cycle, so expiry lands on cycle TIMEOUT_CYC.
  assign o_expired = i_run && (cnt_q == 8'(TIMEOUT_CYC - 1));

endmodule
`default_nettype wire

// File: rtl/mem_stage_dbus.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_stage_dbus: MEM-stage single-beat req/gnt/rvalid bus controller    |
// | Optional response timeout: define MEM_DBUS_TIMEOUT_EN. Revision: 1.0   |
// +----------------------------------------------------------------------+
module mem_stage_dbus
  import mem_pkg::*;
#(
`ifdef MEM_DBUS_TIMEOUT_EN
  parameter int          TIMEOUT_CYC = 255,
`endif
  parameter logic [31:0] ERR_DATA    = c_err_data_default
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUres_MEM,
  input  logic [31:0] MemWd_MEM,
  input  logic        load_MEM,
  input  logic        MemWrite_MEM,
  output logic        mem_stall_MEM,
  output logic [31:0] ReadData_MEM,
  output logic        align_err_MEM,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic        dbus_err
);

  state_t      state_q, state_d;
  dbus_req_t   req_q, req_d;
  logic        req_vld_q, req_vld_d;
  logic [31:0] rdata_q, rdata_d;
  logic        align_err_q, align_err_d;
  logic        dbus_err_q, dbus_err_d;
  logic        w_access;
  logic        w_misaligned;
  logic        w_tmo_expired;

  assign w_access     = load_MEM | MemWrite_MEM;
  assign w_misaligned = (ALUres_MEM[1:0] != 2'b00);

`ifdef MEM_DBUS_TIMEOUT_EN
  logic w_tmo_clear;
  logic w_tmo_run;

  assign w_tmo_clear = (state_q == WAIT_GNT) && dbus_gnt && !dbus_rvalid;
  assign w_tmo_run   = (state_q == WAIT_RESP);

  mem_dbus_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_tmo_clear),
    .i_run     (w_tmo_run),
    .o_expired (w_tmo_expired)
  );
`else
  assign w_tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    req_vld_d     = req_vld_q;
    rdata_d       = rdata_q;
    align_err_d   = 1'b0;
    dbus_err_d    = 1'b0;
    mem_stall_MEM = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_access) begin
          mem_stall_MEM = 1'b1;
          if (w_misaligned) begin
            state_d     = DONE;
            align_err_d = 1'b1;
            rdata_d     = '0;
          end else begin
            state_d     = WAIT_GNT;
            req_vld_d   = 1'b1;
            req_d.we    = MemWrite_MEM;
            req_d.addr  = word_addr(ALUres_MEM);
            req_d.wdata = MemWd_MEM;
          end
        end
      end
      WAIT_GNT: begin
        mem_stall_MEM = 1'b1;
        if (dbus_gnt) begin
          req_vld_d = 1'b0;
          // A response in the grant cycle is taken without visiting WAIT_RESP.
          if (dbus_rvalid) begin
            state_d = DONE;
            if (!req_q.we) rdata_d = dbus_rdata;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        mem_stall_MEM = 1'b1;
        if (dbus_rvalid) begin
          state_d = DONE;
          if (!req_q.we) rdata_d = dbus_rdata;
        end else if (w_tmo_expired) begin
          state_d    = DONE;
          rdata_d    = ERR_DATA;
          dbus_err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      req_q       <= '0;
      req_vld_q   <= 1'b0;
      rdata_q     <= '0;
      align_err_q <= 1'b0;
      dbus_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      req_vld_q   <= req_vld_d;
      rdata_q     <= rdata_d;
      align_err_q <= align_err_d;
      dbus_err_q  <= dbus_err_d;
    end
  end

  assign dbus_req      = req_vld_q;
  assign dbus_we       = req_q.we;
  assign dbus_addr     = req_q.addr;
  assign dbus_wdata    = req_q.wdata;
  assign ReadData_MEM  = rdata_q;
  assign align_err_MEM = align_err_q;
  assign dbus_err      = dbus_err_q;

endmodule
`default_nettype wire
